// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA raster generator: pixel coordinates out, aligned RGB444 and syncs to pins.
module vga_scan_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] color,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        frame_start,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pe;
  logic [10:0]      h_cnt_q, h_cnt_d;
  logic [10:0]      v_cnt_q, v_cnt_d;
  logic             h_last, v_last;
  logic             de_raw, hs_raw, vs_raw;
  logic [PIX_LAT:1] de_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [11:0]      rgb_q;
  logic             hs_q, vs_q, frame_start_q;

  // With CLK_DIV=1 the divider stays at 0 and pe is permanently high.
  assign pe        = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign div_cnt_d = pe ? '0 : div_cnt_q + 1'b1;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pe) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
  end

  assign de_raw = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_raw = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vs_raw = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));

  // Pipe depth matches the colour source latency so RGB and syncs leave together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      de_pipe_q     <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      rgb_q         <= 12'h000;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      frame_start_q <= pe && h_last && v_last;
      if (pe) begin
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
        for (int k = PIX_LAT; k > 1; k--) begin
          de_pipe_q[k] <= de_pipe_q[k-1];
          hs_pipe_q[k] <= hs_pipe_q[k-1];
          vs_pipe_q[k] <= vs_pipe_q[k-1];
        end
        de_pipe_q[1] <= de_raw;
        hs_pipe_q[1] <= hs_raw;
        vs_pipe_q[1] <= vs_raw;
        rgb_q        <= de_pipe_q[PIX_LAT] ? color : 12'h000;
        hs_q         <= hs_pipe_q[PIX_LAT];
        vs_q         <= vs_pipe_q[PIX_LAT];
      end
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign frame_start = frame_start_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb/tb_vga_scan_ctrl.sv - scoreboard bench for vga_scan_ctrl on a shrunken raster, two divider/latency setups.
module tb_vga_scan_ctrl;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int DIV_A = 4, LAT_A = 1;
  localparam int DIV_B = 1, LAT_B = 3;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [11:0] color_a, color_b;
  logic [10:0] x_a, y_a, x_b, y_b;
  logic        fs_a, fs_b, hs_a, hs_b, vs_a, vs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  int   checks = 0;
  int   errors = 0;
  bit   running = 1'b1;
  bit   frc = 1'b0;
  exp_t q_a[$], q_b[$];
  exp_t act_a, act_b;

  always #5 clk = ~clk;

  vga_scan_ctrl #(.CLK_DIV(DIV_A), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .PIX_LAT(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .color(color_a), .x(x_a), .y(y_a), .frame_start(fs_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a));

  vga_scan_ctrl #(.CLK_DIV(DIV_B), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .PIX_LAT(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .color(color_b), .x(x_b), .y(y_b), .frame_start(fs_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b));

  assign act_a = '{x: x_a, y: y_a, rgb: {r_a, g_a, b_a}, hs: hs_a, vs: vs_a, fs: fs_a};
  assign act_b = '{x: x_b, y: y_b, rgb: {r_b, g_b, b_b}, hs: hs_b, vs: vs_b, fs: fs_b};

  function automatic logic [11:0] src_col(logic [10:0] cx, logic [10:0] cy, bit f);
    return f ? 12'hFFF : {cx[3:0], cy[3:0], 4'hA};
  endfunction

  // Upstream colour sources: registered pipelines of the scan coordinate, LAT stages deep.
  logic [1:0]       sdiv_q;
  logic [11:0]      col_a_q;
  logic [2:0][11:0] col_b_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdiv_q  <= '0;
      col_a_q <= '0;
      col_b_q <= '0;
    end else begin
      sdiv_q <= (sdiv_q == 2'(DIV_A - 1)) ? 2'd0 : sdiv_q + 2'd1;
      if (sdiv_q == 2'(DIV_A - 1)) col_a_q <= src_col(x_a, y_a, frc);
      col_b_q <= {col_b_q[1:0], src_col(x_b, y_b, frc)};
    end
  end
  assign color_a = col_a_q;
  assign color_b = col_b_q[2];

  // Expected pin state after the n-th pixel step since reset.
  function automatic exp_t model(int n, bit pe_edge, int lat, bit f);
    exp_t e;
    int m, hh, vv;
    logic [10:0] h11, v11;
    e.x  = 11'(n % HT);
    e.y  = 11'((n / HT) % VT);
    e.fs = pe_edge && (n > 0) && ((n % (HT * VT)) == 0);
    m = n - (lat + 1);
    if (m < 0) begin
      e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
    end else begin
      hh = m % HT; vv = (m / HT) % VT;
      h11 = 11'(hh); v11 = 11'(vv);
      e.hs  = !((hh >= HA + HFP) && (hh < HA + HFP + HSW));
      e.vs  = !((vv >= VA + VFP) && (vv < VA + VFP + VSW));
      e.rgb = ((hh < HA) && (vv < VA)) ? (f ? 12'hFFF : {h11[3:0], v11[3:0], 4'hA}) : 12'h000;
    end
    return e;
  endfunction

  task automatic cmp(string nm, exp_t act, exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got x=%0d y=%0d rgb=%h hs=%b vs=%b fs=%b, want x=%0d y=%0d rgb=%h hs=%b vs=%b fs=%b",
               nm, $time, act.x, act.y, act.rgb, act.hs, act.vs, act.fs,
               exp.x, exp.y, exp.rgb, exp.hs, exp.vs, exp.fs);
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Stimulus side: each clock edge pushes the expected post-edge state of both DUTs.
  int div_m = 0, n_a = 0, n_b = 0;
  bit pe_a;
  always @(posedge clk) begin
    if (running) begin
      if (!rst_n) begin
        div_m = 0; n_a = 0; n_b = 0;
        q_a.push_back(model(0, 1'b0, LAT_A, frc));
        q_b.push_back(model(0, 1'b0, LAT_B, frc));
      end else begin
        pe_a  = (div_m == DIV_A - 1);
        div_m = pe_a ? 0 : div_m + 1;
        if (pe_a) n_a++;
        n_b++;
        q_a.push_back(model(n_a, pe_a, LAT_A, frc));
        q_b.push_back(model(n_b, 1'b1, LAT_B, frc));
      end
    end
  end

  always @(negedge clk) begin
    if (running) begin
      if (q_a.size() == 0) chk("sb_a_empty", 32'(q_a.size()), 32'd1);
      else cmp("sb_a", act_a, q_a.pop_front());
      if (q_b.size() == 0) chk("sb_b_empty", 32'(q_b.size()), 32'd1);
      else cmp("sb_b", act_b, q_b.pop_front());
    end
  end

  localparam exp_t RST_VAL = '{x: 11'd0, y: 11'd0, rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  initial begin
    bit found;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_a", act_a, RST_VAL);
    cmp("async_rst_b", act_b, RST_VAL);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("x_a_after_3", 32'(x_a), 32'd0);
    @(posedge clk);
    #1;
    chk("x_a_after_4", 32'(x_a), 32'd1);
    chk("x_b_after_4", 32'(x_b), 32'd4);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (x_a == 11'd7 && y_a == 11'd7) found = 1'b1;
    end
    chk("wait_px_5_7", 32'(found), 32'd1);
    chk("rgb_px_5_7", 32'({r_a, g_a, b_a}), 32'h57A);
    repeat (1200) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    cmp("mid_rst_a", act_a, RST_VAL);
    cmp("mid_rst_b", act_b, RST_VAL);
    frc = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (1400) @(negedge clk);
    #1 running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
